// File: rtl/perf_pkg.sv
// Shared definitions for the performance-counter dump controller:
// FSM state encoding and default bank geometry.
package perf_pkg;

   localparam int NUM_CTR_DEF = 7;
   localparam int CW_DEF      = 32;
   localparam int IW_DEF      = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      CLEAR  = 2'd2
   } state_e;

endpackage

// File: rtl/perf_counter_ctrl_if.sv
// Host-side request and beat-stream signals of perf_counter_ctrl.
// The master modport is the host; the slave modport is the controller.
interface perf_counter_ctrl_if
   import perf_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int IW = IW_DEF
) ();

   logic          req_valid;
   logic          req_clear;
   logic          req_ready;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;

   modport master (
      output req_valid, req_clear, out_ready,
      input  req_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  req_valid, req_clear, out_ready,
      output req_ready, out_valid, out_data, out_idx, out_last
   );

endinterface

// File: rtl/perf_counter_ctrl.sv
// Coherent snapshot of a counter bank streamed to the host one beat per counter,
// with optional clear strobe. Define PERF_CTRL_DELTA_EN to stream deltas since the previous capture.
module perf_counter_ctrl
   import perf_pkg::*;
#(
   parameter int NUM_CTR = NUM_CTR_DEF,
   parameter int CW      = CW_DEF,
   parameter int IW      = IW_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_CTR*CW-1:0]  ctr_in,
   perf_counter_ctrl_if.slave     bus,
   output logic                   clr_pulse,
   output logic                   busy
);

   if ((2 ** IW) < NUM_CTR) begin : g_bad_iw
      $error("IW too narrow to index NUM_CTR counters");
   end

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CTR - 1);

   state_e        state_q;
   logic [IW-1:0] idx_q;
   logic          clr_pend_q;
   logic          out_valid_q;
   logic          req_ready_q;
   logic          clr_pulse_q;
   logic          busy_q;
   logic [CW-1:0] snap_q [NUM_CTR];
   logic          capture;

   assign capture = (state_q == IDLE) && bus.req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         clr_pend_q  <= 1'b0;
         out_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         clr_pulse_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  state_q     <= STREAM;
                  idx_q       <= '0;
                  clr_pend_q  <= bus.req_clear;
                  out_valid_q <= 1'b1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
               end
            end
            STREAM: begin
               if (bus.out_ready) begin
                  if (idx_q == LAST_IDX) begin
                     out_valid_q <= 1'b0;
                     if (clr_pend_q) begin
                        state_q     <= CLEAR;
                        clr_pulse_q <= 1'b1;
                     end else begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                     end
                  end else begin
                     idx_q <= idx_q + IW'(1);
                  end
               end
            end
            CLEAR: begin
               state_q     <= IDLE;
               clr_pulse_q <= 1'b0;
               clr_pend_q  <= 1'b0;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               clr_pulse_q <= 1'b0;
               req_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: the snapshot bank is reset on purpose so out_data reads 0 until the first capture.
`ifdef PERF_CTRL_DELTA_EN
   // Delta is taken at capture time, so the stream path stays a plain mux.
   logic [CW-1:0] prev_q [NUM_CTR];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CTR; k++) begin
            snap_q[k] <= '0;
            prev_q[k] <= '0;
         end
      end else if (capture) begin
         for (int k = 0; k < NUM_CTR; k++) begin
            snap_q[k] <= ctr_in[k*CW +: CW] - prev_q[k];
            prev_q[k] <= ctr_in[k*CW +: CW];
         end
      end else if (state_q == CLEAR) begin
         for (int k = 0; k < NUM_CTR; k++) begin
            prev_q[k] <= '0;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CTR; k++) begin
            snap_q[k] <= '0;
         end
      end else if (capture) begin
         for (int k = 0; k < NUM_CTR; k++) begin
            snap_q[k] <= ctr_in[k*CW +: CW];
         end
      end
   end
`endif

   assign bus.req_ready = req_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = idx_q;
   assign bus.out_data  = snap_q[idx_q];
   assign bus.out_last  = out_valid_q && (idx_q == LAST_IDX);
   assign clr_pulse     = clr_pulse_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Randomized bench for perf_counter_ctrl against a per-dump reference model
// (expected beat list built from the captured values and the delta history).
module tb_perf_counter_ctrl;
   import perf_pkg::*;

   localparam int NUM_CTR = 7;
   localparam int CW      = 32;
   localparam int IW      = 3;

   typedef logic [CW-1:0] vals_t [NUM_CTR];

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_CTR*CW-1:0] ctr_in = '0;
   logic                  clr_pulse;
   logic                  busy;

   perf_counter_ctrl_if #(.CW(CW), .IW(IW)) bus ();

   perf_counter_ctrl #(.NUM_CTR(NUM_CTR), .CW(CW), .IW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ctr_in    (ctr_in),
      .bus       (bus),
      .clr_pulse (clr_pulse),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int    n_tests = 0;
   int    n_fail  = 0;
   vals_t prev_m;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic rand_ctr();
      for (int i = 0; i < NUM_CTR; i++) ctr_in[i*CW +: CW] = $urandom;
   endtask

   // Entered and left just after a rising edge with the controller idle.
   task automatic dump(input vals_t vals, input bit clr, input int mode);
      vals_t exp_q;
      int    k;
      int    cyc;
      for (int i = 0; i < NUM_CTR; i++) ctr_in[i*CW +: CW] = vals[i];
      bus.req_valid = 1'b1;
      bus.req_clear = clr;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("idle_req_ready", bus.req_ready, 1);
      check("idle_out_valid", bus.out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_clr_pulse", clr_pulse, 0);
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CTR; i++) begin
`ifdef PERF_CTRL_DELTA_EN
         exp_q[i]  = vals[i] - prev_m[i];
         prev_m[i] = clr ? '0 : vals[i];
`else
         exp_q[i]  = vals[i];
`endif
      end
      k   = 0;
      cyc = 0;
      while (k < NUM_CTR && cyc < 200) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom % 2);
            default: bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         endcase
         bus.req_valid = 1'($urandom % 2);
         bus.req_clear = 1'($urandom % 2);
         rand_ctr();
         @(negedge clk);
         check("beat_valid", bus.out_valid, 1);
         check("beat_idx", bus.out_idx, k[IW-1:0]);
         check("beat_data", bus.out_data, exp_q[k]);
         check("beat_last", bus.out_last, k == NUM_CTR - 1);
         check("beat_clr_pulse", clr_pulse, 0);
         check("beat_busy", busy, 1);
         check("beat_req_ready", bus.req_ready, 0);
         @(posedge clk); #1;
         if (bus.out_ready) k++;
         cyc++;
      end
      if (k < NUM_CTR) check("dump_timeout", k, NUM_CTR);
      bus.req_valid = 1'b0;
      bus.req_clear = 1'($urandom % 2);
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("post_clr_pulse", clr_pulse, clr);
      check("post_out_valid", bus.out_valid, 0);
      check("post_req_ready", bus.req_ready, !clr);
      check("post_busy", busy, clr);
      if (clr) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("clr_done_pulse", clr_pulse, 0);
         check("clr_done_req_ready", bus.req_ready, 1);
         check("clr_done_busy", busy, 0);
      end
      @(posedge clk); #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, bus.out_valid, 0);
      check({tag, "_out_last"}, bus.out_last, 0);
      check({tag, "_out_idx"}, bus.out_idx, 0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_clr_pulse"}, clr_pulse, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   task automatic reset_mid_dump();
      for (int i = 0; i < NUM_CTR; i++) ctr_in[i*CW +: CW] = $urandom;
      bus.req_valid = 1'b1;
      bus.req_clear = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         check("rst_pre_idx", bus.out_idx, k[IW-1:0]);
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      for (int i = 0; i < NUM_CTR; i++) prev_m[i] = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_hold_clr_pulse", clr_pulse, 0);
      end
      rst_n = 1'b1;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_after_clr_pulse", clr_pulse, 0);
         check("rst_after_req_ready", bus.req_ready, 1);
         check("rst_after_out_valid", bus.out_valid, 0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vals_t v;
      bus.req_valid = 1'b0;
      bus.req_clear = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NUM_CTR; i++) prev_m[i] = '0;

      rand_ctr();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", bus.req_ready, 1);
      check_reset_outputs("post_reset");
      @(posedge clk); #1;

      for (int i = 0; i < NUM_CTR; i++) v[i] = CW'(10 * (i + 1));
      dump(v, 1'b0, 0);

      for (int i = 0; i < NUM_CTR; i++) v[i] = $urandom;
      v[0] = 32'd5;
      dump(v, 1'b0, 0);

      for (int i = 0; i < NUM_CTR; i++) v[i] = $urandom;
      dump(v, 1'b0, 2);

      for (int i = 0; i < NUM_CTR; i++) v[i] = $urandom;
      dump(v, 1'b1, 0);

      reset_mid_dump();

      for (int i = 0; i < NUM_CTR; i++) v[i] = $urandom;
      v[0] = 32'hFFFF_FFF0;
      dump(v, 1'b0, 0);
      v[0] = 32'h0000_0010;
      dump(v, 1'b0, 1);

      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < NUM_CTR; i++) v[i] = $urandom;
         dump(v, 1'($urandom % 2), int'($urandom % 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/perf_counter_ctrl.md
PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter NUM_CTR, default 7, number of 32-bit event counters served.
REQ-002 Parameter CW, default 32, counter width in bits.
REQ-003 Parameter IW, default 3, index width; SHALL satisfy 2**IW >= NUM_CTR.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ctr_in  input  NUM_CTR*CW  live counter values, flattened; counter k occupies bits [k*CW +: CW].
REQ-007 req_valid  input  1  dump request from host.
REQ-008 req_clear  input  1  qualifier sampled with the req handshake; 1 = clear counters after the dump.
REQ-009 req_ready  output  1  controller can accept a request.
REQ-010 out_valid  output  1  out_data/out_idx/out_last are valid.
REQ-011 out_ready  input  1  host accepts the current beat.
REQ-012 out_data  output  CW  snapshot value of counter out_idx.
REQ-013 out_idx  output  IW  index of the counter being returned.
REQ-014 out_last  output  1  current beat is index NUM_CTR-1.
REQ-015 clr_pulse  output  1  one-cycle synchronous clear strobe to the counter bank.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, STREAM, CLEAR.
REQ-018 IDLE: req_ready=1, out_valid=0; on req_valid&&req_ready, all NUM_CTR values of ctr_in SHALL be latched into the snapshot on the same edge, req_clear latched as clr_pend, idx<=0, next state STREAM.
REQ-019 Snapshot SHALL be coherent: every counter captured in the same cycle; later ctr_in changes SHALL NOT alter streamed data.
REQ-020 STREAM: out_valid=1, req_ready=0, out_data=snap[idx], out_idx=idx, out_last=(idx==NUM_CTR-1).
REQ-021 STREAM with out_valid&&out_ready and idx<NUM_CTR-1: idx<=idx+1, stay in STREAM.
REQ-022 STREAM with out_valid&&out_ready and out_last: next state CLEAR if clr_pend=1, else IDLE.
REQ-023 With out_ready=0 in STREAM, out_data/out_idx/out_last SHALL hold stable and out_valid SHALL stay 1.
REQ-024 CLEAR: clr_pulse=1 for exactly one cycle, then IDLE; clr_pulse SHALL be 0 in all other states.
REQ-025 Dump latency: first beat out_valid SHALL assert the cycle after the request handshake; a full dump with out_ready held 1 takes NUM_CTR cycles in STREAM.
REQ-026 req_valid in STREAM or CLEAR SHALL be ignored, not queued.
REQ-027 req_clear SHALL be ignored unless sampled with a request handshake.

Reset
REQ-028 On rst_n=0, state SHALL become IDLE asynchronously; idx, clr_pend and snapshot SHALL be 0.
REQ-029 During and after reset until the first request: out_valid=0, out_last=0, out_idx=0, out_data=0, clr_pulse=0, busy=0, req_ready=1 once rst_n=1.
REQ-030 Reset asserted mid-dump SHALL abort the dump with no clr_pulse issued.

Configuration
REQ-031 Macro PERF_CTRL_DELTA_EN: when defined, out_data SHALL be snap[k]-prev[k] modulo 2**CW (wrap-correct), prev[k] updated to snap[k] at each capture, prev reset to 0; on CLEAR, prev SHALL be set to 0.
REQ-032 Without PERF_CTRL_DELTA_EN, out_data SHALL be the absolute snapshot and no prev registers SHALL exist.

Structure
REQ-033 Shared package perf_pkg SHALL hold the FSM state encoding and the NUM_CTR/CW defaults.
REQ-034 No sub-module; snapshot bank and FSM are in perf_counter_ctrl.

Verification
REQ-035 Reset, then ctr_in={7 counters = 10,20,...,70}, request with req_clear=0, out_ready=1 -> 7 beats idx 0..6, data 10..70, out_last only on idx 6, no clr_pulse.
REQ-036 Capture at counter0=5, change ctr_in to 99 during STREAM -> beat 0 returns 5.
REQ-037 out_ready toggled 1,0,0,1 during STREAM -> beat held stable while low; no beat duplicated or skipped.
REQ-038 Request with req_clear=1 -> after beat idx 6 accepted, clr_pulse=1 for exactly one cycle, then req_ready=1.
REQ-039 rst_n pulsed low at beat idx 3 -> out_valid=0 immediately, state IDLE, clr_pulse never asserts.
REQ-040 PERF_CTRL_DELTA_EN defined: dumps at counter0=0xFFFFFFF0 then 0x00000010 -> second dump returns 0x20.
